// File: rtl/ahb_ram_responder_pkg.sv
// rtl/ahb_ram_responder_pkg.sv - shared types, defaults and range helper for the AHB RAM responder
package ahb_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH       = 1024;
  localparam int          DEFAULT_WAIT_STATES = 1;
  localparam int          CNT_W               = 4;

  // A borrow in the offset subtraction means the address sits below the region.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({2'b00, off[31:2]} < depth);
  endfunction

endpackage

// File: rtl/ahb_ram_array.sv
// rtl/ahb_ram_array.sv - DEPTH x 32 storage with byte write enables and a registered read port
module ahb_ram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_wen,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wen[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_ram_responder.sv
// rtl/ahb_ram_responder.sv - AHB single-transfer responder serving a word-addressed scratch RAM
module ahb_ram_responder
  import ahb_ram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH       = DEFAULT_DEPTH,
  parameter int          WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        s_ahb_hsel,
  input  logic [31:0] s_ahb_haddr,
  input  logic [31:0] s_ahb_hwdata,
  input  logic [3:0]  s_ahb_hwstrb,
  input  logic        s_ahb_hwrite,
  input  logic [2:0]  s_ahb_hsize,
  input  logic [2:0]  s_ahb_hburst,
  input  logic [3:0]  s_ahb_hprot,
  input  logic [1:0]  s_ahb_htrans,
  input  logic        s_ahb_hmastlock,
  output logic [31:0] s_ahb_hrdata,
  output logic        s_ahb_hready,
  output logic        s_ahb_hresp
);

  localparam int AW = $clog2(DEPTH);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_strb;
  logic               r_write;
  logic               r_hready;
  logic               r_hresp;
  logic [31:0]        r_hrdata;

  logic               w_capture;
  logic               w_issue;
  logic [31:0]        w_req_addr;
  logic [31:0]        w_req_wdata;
  logic [3:0]         w_req_strb;
  logic               w_req_write;
  logic               w_req_ok;
  logic [31:0]        w_req_off;
  logic [3:0]         w_wen;
  logic [31:0]        w_rdata;
  logic               w_resp_ok;
  logic               w_unused;

  assign w_capture = (r_state == ST_IDLE) && s_ahb_hsel;

  // The array is accessed one edge before the response edge so its registered
  // read data is ready to be copied into hrdata; with no wait states that is
  // the capture edge itself, so the live bus inputs are used there.
  assign w_issue = reset &&
                   (((WAIT_STATES == 0) && w_capture) ||
                    ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1))));

  assign w_req_addr  = (WAIT_STATES == 0) ? s_ahb_haddr  : r_addr;
  assign w_req_wdata = (WAIT_STATES == 0) ? s_ahb_hwdata : r_wdata;
  assign w_req_strb  = (WAIT_STATES == 0) ? s_ahb_hwstrb : r_strb;
  assign w_req_write = (WAIT_STATES == 0) ? s_ahb_hwrite : r_write;

  assign w_req_ok  = addr_in_range(w_req_addr, BASE_ADDR, 32'(DEPTH));
  assign w_req_off = w_req_addr - BASE_ADDR;
  assign w_wen     = (w_req_write && w_req_ok) ? w_req_strb : 4'b0000;
  assign w_resp_ok = addr_in_range(r_addr, BASE_ADDR, 32'(DEPTH));

  ahb_ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .i_en    (w_issue && w_req_ok),
    .i_addr  (w_req_off[AW+1:2]),
    .i_wen   (w_wen),
    .i_wdata (w_req_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_write  <= 1'b0;
      r_hready <= 1'b0;
      r_hresp  <= 1'b0;
      r_hrdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hready <= 1'b0;
          r_hresp  <= 1'b0;
          r_hrdata <= '0;
          if (s_ahb_hsel) begin
            r_addr  <= s_ahb_haddr;
            r_wdata <= s_ahb_hwdata;
            r_strb  <= s_ahb_hwstrb;
            r_write <= s_ahb_hwrite;
            r_cnt   <= WAIT_STATES[CNT_W-1:0];
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state  <= ST_RESP;
            r_hready <= 1'b1;
            r_hresp  <= !w_resp_ok;
            r_hrdata <= (w_resp_ok && !r_write) ? w_rdata : 32'h0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b0;
          r_hresp  <= 1'b0;
          r_hrdata <= '0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b0;
          r_hresp  <= 1'b0;
          r_hrdata <= '0;
        end
      endcase
    end
  end

  assign s_ahb_hrdata = r_hrdata;
  assign s_ahb_hready = r_hready;
  assign s_ahb_hresp  = r_hresp;

  assign w_unused = ^{s_ahb_hsize, s_ahb_hburst, s_ahb_hprot, s_ahb_htrans,
                      s_ahb_hmastlock, w_req_off[31:AW+2], w_req_off[1:0]};

endmodule

// File: tb/tb_ahb_ram_responder.sv
// tb/tb_ahb_ram_responder.sv - randomized self-checking bench for three responder configurations
module tb_ahb_ram_responder;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        hsel   [3];
  logic [31:0] haddr  [3];
  logic [31:0] hwdata [3];
  logic [3:0]  hwstrb [3];
  logic        hwrite [3];
  logic [31:0] hrdata [3];
  logic        hready [3];
  logic        hresp  [3];

  logic [2:0] hsize     = 3'b010;
  logic [2:0] hburst    = 3'b000;
  logic [3:0] hprot     = 4'h3;
  logic [1:0] htrans    = 2'b10;
  logic       hmastlock = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [longint];

  ahb_ram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH(1024), .WAIT_STATES(1)) u_w1 (
    .reset(reset), .clock(clock), .s_ahb_hsel(hsel[0]), .s_ahb_haddr(haddr[0]),
    .s_ahb_hwdata(hwdata[0]), .s_ahb_hwstrb(hwstrb[0]), .s_ahb_hwrite(hwrite[0]),
    .s_ahb_hsize(hsize), .s_ahb_hburst(hburst), .s_ahb_hprot(hprot), .s_ahb_htrans(htrans),
    .s_ahb_hmastlock(hmastlock), .s_ahb_hrdata(hrdata[0]), .s_ahb_hready(hready[0]),
    .s_ahb_hresp(hresp[0]));

  ahb_ram_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH(1024), .WAIT_STATES(4)) u_w4 (
    .reset(reset), .clock(clock), .s_ahb_hsel(hsel[1]), .s_ahb_haddr(haddr[1]),
    .s_ahb_hwdata(hwdata[1]), .s_ahb_hwstrb(hwstrb[1]), .s_ahb_hwrite(hwrite[1]),
    .s_ahb_hsize(hsize), .s_ahb_hburst(hburst), .s_ahb_hprot(hprot), .s_ahb_htrans(htrans),
    .s_ahb_hmastlock(hmastlock), .s_ahb_hrdata(hrdata[1]), .s_ahb_hready(hready[1]),
    .s_ahb_hresp(hresp[1]));

  ahb_ram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH(1024), .WAIT_STATES(0)) u_w0 (
    .reset(reset), .clock(clock), .s_ahb_hsel(hsel[2]), .s_ahb_haddr(haddr[2]),
    .s_ahb_hwdata(hwdata[2]), .s_ahb_hwstrb(hwstrb[2]), .s_ahb_hwrite(hwrite[2]),
    .s_ahb_hsize(hsize), .s_ahb_hburst(hburst), .s_ahb_hprot(hprot), .s_ahb_htrans(htrans),
    .s_ahb_hmastlock(hmastlock), .s_ahb_hrdata(hrdata[2]), .s_ahb_hready(hready[2]),
    .s_ahb_hresp(hresp[2]));

  function automatic int ws_of(input int idx);
    case (idx)
      0:       return 1;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic longint base_of(input int idx);
    return (idx == 1) ? 64'h1000 : 64'h0;
  endfunction

  function automatic bit in_range(input int idx, input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= base_of(idx)) && (((ua - base_of(idx)) / 4) < 1024);
  endfunction

  // One complete transfer against the reference model; chained means hsel was
  // already high through the previous response so capture is one edge later.
  task automatic xfer(input int idx, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input bit chained, input bit keep, input string name);
    int          exp_lat;
    int          n;
    bit          seen;
    bit          exp_err;
    logic [31:0] exp_data;
    logic [31:0] cur;
    longint      key;
    exp_err  = !in_range(idx, a);
    exp_data = 32'h0;
    key      = (longint'(idx) << 32) | ((longint'(a) - base_of(idx)) / 4);
    if (!exp_err) begin
      cur = model.exists(key) ? model[key] : 32'h0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        model[key] = cur;
      end else begin
        exp_data = cur;
      end
    end
    exp_lat = ws_of(idx) + (chained ? 3 : 2);
    hsel[idx] = 1'b1; haddr[idx] = a; hwdata[idx] = d; hwstrb[idx] = s; hwrite[idx] = wr;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (hready[idx] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (seen=%0d), expected %0d", name, n, seen, exp_lat);
    end
    if (seen) begin
      checks++;
      if (hresp[idx] !== exp_err) begin
        errors++;
        $display("FAIL %s hresp: got %b, expected %b", name, hresp[idx], exp_err);
      end
      checks++;
      if (hrdata[idx] !== exp_data) begin
        errors++;
        $display("FAIL %s hrdata: got %h, expected %h", name, hrdata[idx], exp_data);
      end
    end
    if (!keep) begin
      hsel[idx] = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (hready[idx] !== 1'b0 || hresp[idx] !== 1'b0 || hrdata[idx] !== 32'h0) begin
        errors++;
        $display("FAIL %s after_pulse: got hready=%b hresp=%b hrdata=%h, expected 0/0/0",
                 name, hready[idx], hresp[idx], hrdata[idx]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hsel[i] = 1'b1; haddr[i] = 32'h10; hwdata[i] = 32'hFFFF_FFFF; hwstrb[i] = 4'hF; hwrite[i] = 1'b0;
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) hsel[i] = 1'b0;
      end
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hready[i] !== 1'b0 || hresp[i] !== 1'b0 || hrdata[i] !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs inst%0d cycle%0d: got hready=%b hresp=%b hrdata=%h, expected 0/0/0",
                   i, c, hready[i], hresp[i], hrdata[i]);
        end
      end
    end
  endtask

  task automatic test_word_rw();
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, "word_write");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "word_read");
  endtask

  task automatic test_strobes();
    xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'h5, 1'b0, 1'b0, "strb_write");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "strb_read");
    xfer(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, 1'b0, "strb_read_low_bits");
    xfer(0, 1'b1, 32'h10, 32'h5555_5555, 4'h0, 1'b0, 1'b0, "strb_zero_write");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "strb_zero_read");
  endtask

  task automatic test_out_of_range();
    xfer(0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF, 1'b0, 1'b0, "oor_seed");
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0, "oor_read");
    xfer(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, "oor_write");
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "oor_noalias");
    xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b0, "oor_top");
    xfer(1, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 1'b0, 1'b0, "oor_below_base");
    xfer(1, 1'b1, 32'h0000_1FFC, 32'hC0DE_0001, 4'hF, 1'b0, 1'b0, "last_word_write");
    xfer(1, 1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 1'b0, 1'b0, "last_word_read");
    xfer(1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 1'b0, 1'b0, "oor_past_end");
  endtask

  task automatic test_reset_mid();
    xfer(1, 1'b1, 32'h1020, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, "mid_seed");
    hsel[1] = 1'b1; haddr[1] = 32'h1020; hwdata[1] = 32'h1234_5678; hwstrb[1] = 4'hF; hwrite[1] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; hsel[1] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      checks++;
      if (hready[1] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_ready cycle%0d: got hready=%b, expected 0", c, hready[1]);
      end
    end
    xfer(1, 1'b0, 32'h1020, 32'h0, 4'h0, 1'b0, 1'b0, "mid_reset_read");
  endtask

  task automatic test_back_to_back();
    xfer(2, 1'b1, 32'h40, 32'h0102_0304, 4'hF, 1'b0, 1'b1, "b2b_w0");
    xfer(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1, "b2b_r0");
    xfer(2, 1'b1, 32'h44, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1, "b2b_w1");
    xfer(2, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b1, "b2b_r1");
    xfer(2, 1'b1, 32'h44, 32'h7777_8888, 4'hA, 1'b1, 1'b1, "b2b_w2");
    xfer(2, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0, "b2b_r2");
  endtask

  task automatic test_random();
    int          idx;
    int          op;
    logic [31:0] a;
    logic [31:0] base;
    for (int i = 0; i < 3; i++) begin
      for (int slot = 0; slot < 8; slot++) begin
        base = 32'(base_of(i));
        xfer(i, 1'b1, base + 32'h100 + 32'(slot * 4), $urandom, 4'hF, 1'b0, 1'b0, "rnd_init");
      end
    end
    for (int n = 0; n < 40; n++) begin
      idx  = $urandom_range(0, 2);
      op   = $urandom_range(0, 3);
      base = 32'(base_of(idx));
      a    = base + 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if (op == 3) a = base + 32'h1000 + 32'($urandom_range(0, 255) * 4);
      if (op == 3 && idx == 1 && $urandom_range(0, 1) == 1) a = base - 32'($urandom_range(1, 64) * 4);
      xfer(idx, (op == 0 || (op == 3 && $urandom_range(0, 1) == 1)), a, $urandom,
           4'($urandom_range(0, 15)), 1'b0, 1'b0, "rnd_xfer");
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      hsel[i] = 1'b0; haddr[i] = '0; hwdata[i] = '0; hwstrb[i] = '0; hwrite[i] = 1'b0;
    end
    @(posedge clock); #1;
    test_reset();
    test_word_rw();
    test_strobes();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
